// File: rtl/gaussian_stream_ctrl_if.sv
// Control/status bundle between a frame sequencer (master) and the
// Gaussian stencil stream controller (slave).
interface gaussian_stream_ctrl_if;
    logic        flush;
    logic        start;
    logic        stall;
    logic        read_en;
    logic        pipe_en;
    logic        write_valid;
    logic [15:0] row;
    logic [15:0] col;
    logic [31:0] out_count;
    logic        busy;
    logic        done;

    modport master (
        output flush, start, stall,
        input  read_en, pipe_en, write_valid, row, col, out_count, busy, done
    );

    modport slave (
        input  flush, start, stall,
        output read_en, pipe_en, write_valid, row, col, out_count, busy, done
    );
endinterface

// File: rtl/gaussian_stream_ctrl.sv
// Frame sequencer for a KSIZE x KSIZE stencil datapath: raster-scans the image,
// tracks which reads produce a valid output word and drains the pipeline.
module gaussian_stream_ctrl #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int KSIZE   = 3,
    parameter int LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    gaussian_stream_ctrl_if.slave        bus
);

    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [15:0]   LAST_ROW   = 16'(IMG_H - 1);
    localparam logic [15:0]   LAST_COL   = 16'(IMG_W - 1);
    localparam logic [15:0]   EDGE       = 16'(KSIZE - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [15:0]          row_r;
    logic [15:0]          col_r;
    logic [31:0]          out_count_r;
    logic [DW-1:0]        drain_cnt_r;
    logic [LATENCY-1:0]   dly_r;
    logic [LATENCY:0]     dly_ext_s;
    logic                 interior_s;
    logic                 last_pix_s;
    logic                 enter_run_s;
    logic                 read_en_s;
    logic                 pipe_en_s;
    logic                 write_valid_s;
    logic                 busy_s;
    logic                 done_s;

    assign last_pix_s  = (row_r == LAST_ROW) && (col_r == LAST_COL);
    assign interior_s  = (row_r >= EDGE) && (col_r >= EDGE);
    assign enter_run_s = (state_r == ST_IDLE) && bus.start && !bus.flush;
    // Non-read advance cycles push a bubble so drained words never look valid.
    assign dly_ext_s   = {dly_r, (read_en_s & interior_s)};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush overrides every transition including start.
    always_comb begin
        state_s = state_r;
        if (bus.flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) state_s = ST_RUN;
                    else           state_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (read_en_s && last_pix_s) state_s = ST_DRAIN;
                    else                         state_s = ST_RUN;
                end
                ST_DRAIN: begin
                    if (!bus.stall && (drain_cnt_r == DRAIN_LAST)) state_s = ST_DONE;
                    else                                           state_s = ST_DRAIN;
                end
                ST_DONE:  state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the current state and the live stall request.
    always_comb begin
        read_en_s     = 1'b0;
        pipe_en_s     = 1'b0;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE:  busy_s = 1'b0;
            ST_RUN: begin
                busy_s    = 1'b1;
                read_en_s = !bus.stall;
                pipe_en_s = !bus.stall;
            end
            ST_DRAIN: begin
                busy_s    = 1'b1;
                pipe_en_s = !bus.stall;
            end
            ST_DONE:  done_s = 1'b1;
            default:  busy_s = 1'b0;
        endcase
        if (pipe_en_s) write_valid_s = dly_r[LATENCY-1];
        else           write_valid_s = 1'b0;
    end

    // Scan counters, output counter, drain counter and validity delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r       <= 16'd0;
            col_r       <= 16'd0;
            out_count_r <= 32'd0;
            drain_cnt_r <= '0;
            dly_r       <= '0;
        end else if (bus.flush) begin
            row_r       <= 16'd0;
            col_r       <= 16'd0;
            out_count_r <= 32'd0;
            drain_cnt_r <= '0;
            dly_r       <= '0;
        end else if (enter_run_s) begin
            row_r       <= 16'd0;
            col_r       <= 16'd0;
            out_count_r <= 32'd0;
            drain_cnt_r <= '0;
        end else begin
            // The last pixel leaves row/col parked until the next start.
            if (read_en_s && !last_pix_s) begin
                if (col_r == LAST_COL) begin
                    col_r <= 16'd0;
                    row_r <= row_r + 16'd1;
                end else begin
                    col_r <= col_r + 16'd1;
                end
            end
            if (write_valid_s) out_count_r <= out_count_r + 32'd1;
            if ((state_r == ST_DRAIN) && !bus.stall) drain_cnt_r <= drain_cnt_r + DW'(1);
            if (pipe_en_s) dly_r <= dly_ext_s[LATENCY-1:0];
        end
    end

    assign bus.read_en     = read_en_s;
    assign bus.pipe_en     = pipe_en_s;
    assign bus.write_valid = write_valid_s;
    assign bus.busy        = busy_s;
    assign bus.done        = done_s;
    assign bus.row         = row_r;
    assign bus.col         = col_r;
    assign bus.out_count   = out_count_r;

endmodule

// File: tb/tb_gaussian_stream_ctrl.sv
// Bench for gaussian_stream_ctrl: a 4x4/K3/L2 instance against a frame-level
// reference model, plus a default 64x64 instance for whole-frame totals.
module tb_gaussian_stream_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int K = 3;
    localparam int L = 2;
    localparam int N = W * H;

    logic clk;
    logic rst_n;
    int   n_asserts = 0;
    int   n_fail    = 0;

    // Reference model: frame seen as a count of enabled cycles since start.
    int   m_phase;   // 0 idle, 1 busy (run+drain), 2 done
    int   m_e;       // enabled cycles taken in this frame
    int   m_reads;   // pixels read in this frame
    int   m_cnt;     // expected out_count
    logic obs_done;

    gaussian_stream_ctrl_if sb();
    gaussian_stream_ctrl_if bb();

    gaussian_stream_ctrl #(.IMG_W(W), .IMG_H(H), .KSIZE(K), .LATENCY(L)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb)
    );

    gaussian_stream_ctrl dut_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit interior(input int p);
        return ((p / W) >= K - 1) && ((p % W) >= K - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_phase = 0;
        m_e     = 0;
        m_reads = 0;
        m_cnt   = 0;
    endtask

    task automatic cycle(input bit st, input bit sl, input bit fl);
        bit en, rd, wv;
        int k, pix;
        sb.start = st;
        sb.stall = sl;
        sb.flush = fl;
        @(negedge clk);
        en  = (m_phase == 1) && !sl;
        k   = m_e + 1;
        rd  = en && (k <= N);
        wv  = en && (k > L) && interior(k - L - 1);
        pix = (m_reads >= N) ? N - 1 : m_reads;
        chk("read_en",     {31'd0, sb.read_en},     {31'd0, rd});
        chk("pipe_en",     {31'd0, sb.pipe_en},     {31'd0, en});
        chk("write_valid", {31'd0, sb.write_valid}, {31'd0, wv});
        chk("row",         {16'd0, sb.row},         pix / W);
        chk("col",         {16'd0, sb.col},         pix % W);
        chk("out_count",   sb.out_count,            m_cnt);
        chk("busy",        {31'd0, sb.busy},        {31'd0, (m_phase == 1)});
        chk("done",        {31'd0, sb.done},        {31'd0, (m_phase == 2)});
        obs_done = sb.done;
        if (fl) begin
            model_clear();
        end else if (m_phase == 0) begin
            if (st) begin
                model_clear();
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (en) begin
                m_e = k;
                if (rd) m_reads++;
                if (wv) m_cnt++;
                if (k == N + L) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_read_en",     {31'd0, sb.read_en},     32'd0);
        chk("rst_pipe_en",     {31'd0, sb.pipe_en},     32'd0);
        chk("rst_write_valid", {31'd0, sb.write_valid}, 32'd0);
        chk("rst_busy",        {31'd0, sb.busy},        32'd0);
        chk("rst_done",        {31'd0, sb.done},        32'd0);
        chk("rst_row",         {16'd0, sb.row},         32'd0);
        chk("rst_col",         {16'd0, sb.col},         32'd0);
        chk("rst_out_count",   sb.out_count,            32'd0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int big_rd, big_wv, big_dn;
        bit big_seen;
        rst_n    = 1'b1;
        sb.start = 1'b0; sb.stall = 1'b0; sb.flush = 1'b0;
        bb.start = 1'b0; bb.stall = 1'b0; bb.flush = 1'b0;
        model_clear();
        #3;
        do_reset();

        // Plain frame: done expected exactly 19 cycles after start.
        for (int i = 0; i <= 22; i++) begin
            cycle(i == 0, 1'b0, 1'b0);
            if (i == 19) chk("done_at_t19", {31'd0, obs_done}, 32'd1);
        end

        // Three stall cycles mid-run push done to t+22.
        for (int i = 0; i <= 25; i++) begin
            cycle(i == 0, (i >= 5) && (i <= 7), 1'b0);
            if (i == 22) chk("done_at_t22", {31'd0, obs_done}, 32'd1);
        end

        // Second start during RUN is ignored.
        for (int i = 0; i <= 22; i++) begin
            cycle((i == 0) || (i == 8), 1'b0, 1'b0);
            if (i == 19) chk("restart_done_t19", {31'd0, obs_done}, 32'd1);
        end

        // Flush while a valid word is in flight, then a clean frame.
        for (int i = 0; i <= 20; i++) cycle(i == 0, 1'b0, i == 12);
        for (int i = 0; i <= 22; i++) cycle(i == 0, 1'b0, 1'b0);

        // Flush and start together in IDLE: flush wins.
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Reset mid-frame, then a fresh frame from pixel 0.
        for (int i = 0; i < 10; i++) cycle(i == 0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i <= 22; i++) cycle(i == 0, 1'b0, 1'b0);

        // Random starts, stalls and flushes.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 99) == 0);

        // Default-size frame on the second instance.
        big_rd = 0; big_wv = 0; big_dn = 0; big_seen = 1'b0;
        bb.start = 1'b1;
        @(posedge clk);
        #1;
        bb.start = 1'b0;
        for (int i = 0; i < 8000 && !big_seen; i++) begin
            bb.stall = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (bb.read_en)     big_rd++;
            if (bb.write_valid) big_wv++;
            if (bb.done) begin
                big_dn++;
                big_seen = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bb.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bb.done) big_dn++;
            @(posedge clk);
            #1;
        end
        chk("big_done_seen",   {31'd0, big_seen}, 32'd1);
        chk("big_read_count",  big_rd,            32'd4096);
        chk("big_write_count", big_wv,            32'd3844);
        chk("big_done_pulses", big_dn,            32'd1);
        chk("big_out_count",   bb.out_count,      32'd3844);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/gaussian_stream_ctrl.md
GAUSSIAN_STREAM_CTRL -- requirements
Module: gaussian_stream_ctrl

Interface
REQ-001 Parameter IMG_W, default 64: image width in pixels (>= KSIZE).
REQ-002 Parameter IMG_H, default 64: image height in pixels (>= KSIZE).
REQ-003 Parameter KSIZE, default 3: square stencil window size.
REQ-004 Parameter LATENCY, default 4: datapath depth in enabled cycles, from input read to output word (>= 1).
REQ-005 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1: asynchronous, active-low reset.
REQ-007 flush  input  1: synchronous abort/clear, active high.
REQ-008 start  input  1: one-cycle frame start request.
REQ-009 stall  input  1: downstream/upstream hold request.
REQ-010 read_en  output  1: pulls one input pixel from the datapath this cycle.
REQ-011 pipe_en  output  1: datapath advance enable.
REQ-012 write_valid  output  1: datapath output word is valid this cycle.
REQ-013 row, col  output  16 each: coordinates of the pixel read this cycle.
REQ-014 out_count  output  32: number of write_valid pulses in the current frame.
REQ-015 busy  output  1: high in RUN or DRAIN.
REQ-016 done  output  1: one-cycle frame-complete pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
  - IDLE->RUN on start.
  - RUN->DRAIN after the read of pixel (IMG_H-1, IMG_W-1).
  - DRAIN->DONE after LATENCY non-stalled cycles.
  - DONE->IDLE unconditionally.
REQ-018 read_en SHALL be high only in RUN and when stall is low.
REQ-019 pipe_en SHALL be high when in RUN or DRAIN and stall is low.
REQ-020 row and col SHALL scan raster order: col wraps IMG_W-1->0 with row+1, each step advanced only by a read_en cycle.
REQ-021 row and col SHALL reset to 0 on entering RUN.
REQ-022 Pixel (r,c) SHALL be interior when r >= KSIZE-1 and c >= KSIZE-1.
REQ-023 The interior flag SHALL enter a LATENCY-deep delay line on each read_en cycle and a 0 on every other pipe_en cycle.
REQ-024 The delay line SHALL shift only when pipe_en is high.
REQ-025 write_valid SHALL equal the delay-line output AND pipe_en.
  - An interior pixel read in cycle n with no stall asserts write_valid in cycle n+LATENCY.
REQ-026 out_count SHALL increment on write_valid, clear on entering RUN, and hold through DONE and IDLE.
  - The final value SHALL be (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1).
REQ-027 done SHALL be high exactly in the DONE state.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 Stall SHALL freeze the counters, the FSM and the delay line.
  - In IDLE or DONE, stall SHALL have no effect.
REQ-030 While flush is high, the block SHALL go to IDLE next cycle and clear row, col, the delay line and out_count; done SHALL not pulse.
REQ-031 When flush and start are high in the same cycle, flush SHALL win.
REQ-032 The counter wrap at the last pixel SHALL not re-enter RUN.
  - Row and col SHALL hold their final values until the next start.

Reset
REQ-033 While rst_n is low, regardless of clk:
  - the state SHALL be IDLE;
  - row, col and out_count SHALL be 0;
  - the delay line SHALL be cleared;
  - read_en, pipe_en, write_valid, busy and done SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no done pulse.
  - Operation SHALL resume only on a fresh start after rst_n rises.

Verification
REQ-035 (IMG_W=IMG_H=4, KSIZE=3, LATENCY=2) start at cycle t, no stall:
  - read_en high t+1..t+16;
  - write_valid at t+13, t+14, t+17, t+18;
  - done at t+19;
  - out_count=4, busy low from t+19.
REQ-036 Same config, stall high at t+5..t+7:
  - read_en low for those 3 cycles;
  - all later events shift by 3 (done at t+22);
  - out_count=4.
REQ-037 Start pulsed again at t+8 during RUN:
  - ignored; identical timing to REQ-035.
REQ-038 Flush at t+12 (after first write_valid is pending):
  - IDLE at t+13;
  - no further write_valid, no done;
  - out_count=0.
  - A new start then yields the full REQ-035 sequence.
REQ-039 rst_n low at t+10 for 2 cycles:
  - all outputs 0 immediately;
  - no done;
  - next start restarts from row=col=0.
REQ-040 Default parameters (64x64), single start:
  - exactly 4096 read_en cycles and 3844 write_valid cycles;
  - one done pulse.
